pipe_stage_reg: RTL

- Parametrised pipeline stage register for inter-stage boundaries (ID/EXE, EXE/MEM, MEM/WB). Generalises the fixed-field stage register.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and control-bit bubble squashing.
- Adds a saturating back-pressure counter for performance debug.
- Sits between two pipeline stages. The upstream stage drives in_*; the downstream stage consumes out_*.

---
 rtl/pipe_stage_reg_if.sv | 19 +
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream bundle used on both sides of a pipeline stage register.
// Ports (signals):
//   valid  producer -> consumer  entry valid
//   ready  consumer -> producer  consumer accepts the entry this cycle
//   data   producer -> consumer  payload, DATA_W bits
//   ctrl   producer -> consumer  control bits, CTRL_W bits
// Modports: master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, control-bit bubble squashing and a saturating
// back-pressure (stall) counter.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous kill of all held entries
//   clr_cnt    synchronous clear of stall_cnt
//   in_if      upstream stream (slave): valid/data/ctrl in, ready out
//   out_if     downstream stream (master): valid/data/ctrl out, ready in
//   level      occupancy 0, 1 or 2
//   stall_cnt  cycles with out valid and not ready, saturating
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | nothing held, accepting
// S_FULL  | main register holds the head entry, accepting
// S_SKID  | main and skid registers both hold entries, stalling upstream
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_cnt,
  pipe_stage_reg_if.slave   in_if,
  pipe_stage_reg_if.master  out_if,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_d;
  logic              alive;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_ready_i, out_valid_i;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid_i = (state != S_EMPTY);

  // alive keeps in_ready low during reset and for the rest of that cycle.
  if (SKID != 0) begin : g_skid
    assign in_ready_i = alive & (state != S_SKID);
  end else begin : g_noskid
    assign in_ready_i = alive & (~out_valid_i | out_if.ready);
  end

  assign in_fire  = in_if.valid & in_ready_i;
  assign out_fire = out_valid_i & out_if.ready;

  assign in_if.ready  = in_ready_i;
  assign out_if.valid = out_valid_i;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = main_ctrl & {CTRL_W{out_valid_i}};
  assign level        = state;

  always_comb begin
    state_d        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_FULL;
            load_main_in = 1'b1;
          end
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            // Without a skid buffer in_ready already excludes this case.
            if (SKID != 0) begin
              state_d   = S_SKID;
              load_skid = 1'b1;
            end
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_SKID: begin
          if (out_fire) begin
            state_d        = S_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_EMPTY;
      alive <= 1'b0;
    end else begin
      state <= state_d;
      alive <= 1'b1;
    end
  end

  // Data may go stale on flush; only ctrl has to be scrubbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_if.data;
        main_ctrl <= in_if.ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_if.data;
        skid_ctrl <= in_if.ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid_i && !out_if.ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
